// File: rtl/usart_pkg.sv
// Shared definitions for the USART receive and transmit buffering blocks.
package usart_pkg;

    typedef enum logic {
        WAIT_BYTE = 1'b0,
        ACK_BYTE  = 1'b1
    } rx_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO.
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [DEPTH_LOG2-1:0] write_ptr;
    logic [DEPTH_LOG2-1:0] read_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = storage[read_ptr];

    // A full FIFO still accepts a push when a pop frees the head slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
        end else begin
            if (do_push) write_ptr <= write_ptr + 1'b1;
            if (do_pop)  read_ptr  <= read_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) storage[write_ptr] <= push_data;
    end

endmodule

// File: rtl/usart_rx_buffer.sv
// Receive buffer: acknowledges usart_rx bytes into a FWFT FIFO
// and keeps sticky overrun / framing-error status.
module usart_rx_buffer
    import usart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  comm_clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_available,
    input  logic                  rx_error,
    output logic                  rx_acknowledge,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  not_empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    input  logic                  pop,
    output logic                  overrun,
    output logic                  framing_error,
    input  logic                  clear_status
);

    rx_state_t state;
    rx_state_t state_next;
    logic      ack_next;
    logic      accept;
    logic      empty;
    logic      overrun_set;
    logic      framing_set;

    assign not_empty = !empty;

    sync_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk      (comm_clock),
        .reset    (reset),
        .push     (accept),
        .push_data(rx_data),
        .pop      (pop),
        .pop_data (data_out),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        state_next = state;
        ack_next   = 1'b0;
        accept     = 1'b0;
        unique case (state)
            WAIT_BYTE: begin
                if (rx_available) begin
                    accept     = 1'b1;
                    ack_next   = 1'b1;
                    state_next = ACK_BYTE;
                end
            end
            ACK_BYTE: begin
                // Stay here until usart_rx withdraws available.
                if (rx_available) begin
                    ack_next = 1'b1;
                end else begin
                    state_next = WAIT_BYTE;
                end
            end
            default: state_next = WAIT_BYTE;
        endcase
    end

    assign overrun_set = accept && full && !pop;
    assign framing_set = accept && rx_error;

    always_ff @(posedge comm_clock) begin
        if (reset) begin
            state          <= WAIT_BYTE;
            rx_acknowledge <= 1'b0;
            overrun        <= 1'b0;
            framing_error  <= 1'b0;
        end else begin
            state          <= state_next;
            rx_acknowledge <= ack_next;
            if (overrun_set)       overrun <= 1'b1;
            else if (clear_status) overrun <= 1'b0;
            if (framing_set)       framing_error <= 1'b1;
            else if (clear_status) framing_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_usart_rx_buffer.sv
// Directed self-checking bench for usart_rx_buffer.
module tb_usart_rx_buffer;

    logic       comm_clock = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_available;
    logic       rx_error;
    logic       rx_acknowledge;
    logic [7:0] data_out;
    logic       not_empty;
    logic       full;
    logic [4:0] count;
    logic       pop;
    logic       overrun;
    logic       framing_error;
    logic       clear_status;

    int tests = 0;
    int fails = 0;

    always #5 comm_clock = ~comm_clock;

    usart_rx_buffer #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
        .comm_clock    (comm_clock),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_available  (rx_available),
        .rx_error      (rx_error),
        .rx_acknowledge(rx_acknowledge),
        .data_out      (data_out),
        .not_empty     (not_empty),
        .full          (full),
        .count         (count),
        .pop           (pop),
        .overrun       (overrun),
        .framing_error (framing_error),
        .clear_status  (clear_status)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge comm_clock);
    endtask

    task automatic send(input logic [7:0] d, input logic err);
        rx_data      = d;
        rx_error     = err;
        rx_available = 1'b1;
        step();
        rx_available = 1'b0;
        rx_error     = 1'b0;
        step();
    endtask

    task automatic pop_one();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        rx_data      = 8'h00;
        rx_available = 1'b0;
        rx_error     = 1'b0;
        pop          = 1'b0;
        clear_status = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_count", 32'(count), 0);
        check("rst_not_empty", 32'(not_empty), 0);
        check("rst_full", 32'(full), 0);
        check("rst_ack", 32'(rx_acknowledge), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_framing", 32'(framing_error), 0);

        // Single byte held available for five cycles
        rx_data      = 8'h41;
        rx_available = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("single_ack_hi", 32'(rx_acknowledge), 1);
            check("single_count", 32'(count), 1);
        end
        rx_available = 1'b0;
        step();
        check("single_ack_lo", 32'(rx_acknowledge), 0);
        check("single_count_after", 32'(count), 1);
        check("single_data", 32'(data_out), 32'h41);
        check("single_not_empty", 32'(not_empty), 1);
        pop_one();
        check("single_popped", 32'(count), 0);

        // Fill past capacity
        for (int i = 0; i <= 16; i++) send(8'(i), 1'b0);
        check("fill_count", 32'(count), 16);
        check("fill_full", 32'(full), 1);
        check("fill_overrun", 32'(overrun), 1);
        for (int i = 0; i < 16; i++) begin
            check("fill_order", 32'(data_out), 32'(i));
            pop_one();
        end
        check("drain_count", 32'(count), 0);
        check("drain_not_empty", 32'(not_empty), 0);
        check("drain_full", 32'(full), 0);
        check("overrun_sticky", 32'(overrun), 1);
        pop_one();
        check("pop_empty_ignored", 32'(count), 0);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("overrun_cleared", 32'(overrun), 0);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b0);
        check("full2_count", 32'(count), 16);
        rx_data      = 8'hAA;
        rx_available = 1'b1;
        pop          = 1'b1;
        step();
        pop          = 1'b0;
        rx_available = 1'b0;
        step();
        check("pushpop_count", 32'(count), 16);
        check("pushpop_overrun", 32'(overrun), 0);
        for (int i = 1; i < 16; i++) begin
            check("pushpop_order", 32'(data_out), 32'(8'h20 + i));
            pop_one();
        end
        check("pushpop_last", 32'(data_out), 32'hAA);
        pop_one();
        check("pushpop_empty", 32'(count), 0);

        // Framing error handling
        send(8'h55, 1'b1);
        check("fe_data", 32'(data_out), 32'h55);
        check("fe_flag", 32'(framing_error), 1);
        rx_data      = 8'h56;
        rx_error     = 1'b1;
        rx_available = 1'b1;
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        rx_available = 1'b0;
        rx_error     = 1'b0;
        step();
        check("fe_set_wins", 32'(framing_error), 1);
        check("fe_count", 32'(count), 2);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("fe_cleared", 32'(framing_error), 0);
        check("fe_head", 32'(data_out), 32'h55);
        pop_one();
        check("fe_second", 32'(data_out), 32'h56);
        pop_one();
        check("fe_empty", 32'(count), 0);

        // Pointer wrap with single-entry occupancy
        for (int i = 0; i < 40; i++) begin
            send(8'(8'h80 + i), 1'b0);
            check("wrap_count", 32'(count), 1);
            check("wrap_data", 32'(data_out), 32'(8'h80 + i));
            pop_one();
            check("wrap_empty", 32'(count), 0);
        end

        // Reset while acknowledging
        rx_data      = 8'h99;
        rx_error     = 1'b1;
        rx_available = 1'b1;
        step();
        check("rack_ack", 32'(rx_acknowledge), 1);
        check("rack_fe", 32'(framing_error), 1);
        check("rack_count", 32'(count), 1);
        reset = 1'b1;
        step();
        check("rack_rst_ack", 32'(rx_acknowledge), 0);
        check("rack_rst_count", 32'(count), 0);
        check("rack_rst_fe", 32'(framing_error), 0);
        check("rack_rst_ov", 32'(overrun), 0);
        reset    = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'h3C;
        step();
        check("rack_new_count", 32'(count), 1);
        check("rack_new_ack", 32'(rx_acknowledge), 1);
        check("rack_new_data", 32'(data_out), 32'h3C);
        step();
        step();
        check("rack_single_store", 32'(count), 1);
        rx_available = 1'b0;
        step();
        check("rack_ack_drop", 32'(rx_acknowledge), 0);
        check("rack_fe_clean", 32'(framing_error), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
